// File: rtl/lcd_power_sequencer_pkg.sv
// Shared types, state encoding and default timing for the LCD panel power sequencer.
package lcd_power_sequencer_pkg;

  localparam int unsigned TIMER_W = 24;

  localparam int unsigned DEF_T_VDD_LVDS    = 10;
  localparam int unsigned DEF_BLANK_FRAMES  = 2;
  localparam int unsigned DEF_T_BL_ON       = 8;
  localparam int unsigned DEF_T_BL_OFF      = 8;
  localparam int unsigned DEF_T_LVDS_OFF    = 6;
  localparam int unsigned DEF_T_COOL        = 20;
  localparam int unsigned DEF_VSYNC_TIMEOUT = 100;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_VDD_ON    = 3'd1,
    ST_LVDS_WAIT = 3'd2,
    ST_BL_WAIT   = 3'd3,
    ST_RUN       = 3'd4,
    ST_BL_OFF    = 3'd5,
    ST_LVDS_OFF  = 3'd6,
    ST_COOL      = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic vdd;
    logic lvds;
    logic blank;
    logic backlight;
    logic ready;
  } panel_ctrl_t;

  // Panel control levels held while the sequencer sits in a given state.
  function automatic panel_ctrl_t decode_state(input seq_state_t s);
    panel_ctrl_t c;
    c = '0;
    case (s)
      ST_VDD_ON:    c.vdd = 1'b1;
      ST_LVDS_WAIT: begin c.vdd = 1'b1; c.lvds = 1'b1; c.blank = 1'b1; end
      ST_BL_WAIT:   begin c.vdd = 1'b1; c.lvds = 1'b1; end
      ST_RUN:       begin c.vdd = 1'b1; c.lvds = 1'b1; c.backlight = 1'b1; c.ready = 1'b1; end
      ST_BL_OFF:    begin c.vdd = 1'b1; c.lvds = 1'b1; c.blank = 1'b1; end
      ST_LVDS_OFF:  c.vdd = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// 24-bit cycle counter with synchronous clear, count enable and compare-to-limit.
module seq_timer
  import lcd_power_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               count,
  input  logic [TIMER_W-1:0] limit,
  output logic               done_c
);

  logic [TIMER_W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (count) begin
      value <= value + TIMER_W'(1);
    end
  end

  assign done_c = (value == limit);

endmodule

// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer: VDD -> LVDS -> blanked frames -> backlight, with
// orderly shutdown, cool-down and a sticky vsync watchdog fault.
module lcd_power_sequencer
  import lcd_power_sequencer_pkg::*;
#(
  parameter int unsigned T_VDD_LVDS    = DEF_T_VDD_LVDS,
  parameter int unsigned BLANK_FRAMES  = DEF_BLANK_FRAMES,
  parameter int unsigned T_BL_ON       = DEF_T_BL_ON,
  parameter int unsigned T_BL_OFF      = DEF_T_BL_OFF,
  parameter int unsigned T_LVDS_OFF    = DEF_T_LVDS_OFF,
  parameter int unsigned T_COOL        = DEF_T_COOL,
  parameter int unsigned VSYNC_TIMEOUT = DEF_VSYNC_TIMEOUT
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       enableRequest,
  input  logic       vsync,
  output logic       panelVddEn,
  output logic       lvdsEnable,
  output logic       blankData,
  output logic       backlightEn,
  output logic       panelReady,
  output logic       fault,
  output logic [2:0] seqState
);

  localparam logic [TIMER_W-1:0] LIM_VDD_LVDS = TIMER_W'(T_VDD_LVDS - 1);
  localparam logic [TIMER_W-1:0] LIM_FRAMES   = TIMER_W'(BLANK_FRAMES - 1);
  localparam logic [TIMER_W-1:0] LIM_BL_ON    = TIMER_W'(T_BL_ON - 1);
  localparam logic [TIMER_W-1:0] LIM_BL_OFF   = TIMER_W'(T_BL_OFF - 1);
  localparam logic [TIMER_W-1:0] LIM_LVDS_OFF = TIMER_W'(T_LVDS_OFF - 1);
  localparam logic [TIMER_W-1:0] LIM_COOL     = TIMER_W'(T_COOL - 1);
  localparam logic [TIMER_W-1:0] LIM_WD       = TIMER_W'(VSYNC_TIMEOUT - 1);

  seq_state_t         state, state_next;
  logic               fault_next;
  logic               vsync_q;
  logic               vsync_rise_c;
  logic [TIMER_W-1:0] frame_cnt;
  logic [TIMER_W-1:0] tmr_limit;
  logic               tmr_done_c;
  logic               wd_done_c;
  logic               wd_active_c;
  logic               timeout_c;
  logic               enter_lvds_wait_c;
  panel_ctrl_t        ctrl;

  assign vsync_rise_c      = vsync & ~vsync_q;
  assign wd_active_c       = (state == ST_LVDS_WAIT) || (state == ST_BL_WAIT) || (state == ST_RUN);
  // An edge landing on the expiry cycle still counts as a live frame.
  assign timeout_c         = wd_active_c & wd_done_c & ~vsync_rise_c;
  assign enter_lvds_wait_c = (state_next == ST_LVDS_WAIT) && (state != ST_LVDS_WAIT);

  seq_timer u_state_timer (
    .clk    (pixelClock),
    .rst    (reset),
    .clear  (state_next != state),
    .count  (1'b1),
    .limit  (tmr_limit),
    .done_c (tmr_done_c)
  );

  seq_timer u_vsync_wd (
    .clk    (pixelClock),
    .rst    (reset),
    .clear  (enter_lvds_wait_c | vsync_rise_c),
    .count  (wd_active_c),
    .limit  (LIM_WD),
    .done_c (wd_done_c)
  );

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state   <= ST_OFF;
      fault   <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state   <= state_next;
      fault   <= fault_next;
      vsync_q <= vsync;
    end
  end

  // Blanked-frame counter, restarted on every LVDS_WAIT entry.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (enter_lvds_wait_c) begin
      frame_cnt <= '0;
    end else if ((state == ST_LVDS_WAIT) && vsync_rise_c) begin
      frame_cnt <= frame_cnt + TIMER_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    fault_next = fault;
    tmr_limit  = '0;
    case (state)
      ST_OFF: begin
        if (!enableRequest)   fault_next = 1'b0;
        else if (!fault)      state_next = ST_VDD_ON;
      end
      ST_VDD_ON: begin
        tmr_limit = LIM_VDD_LVDS;
        if (!enableRequest)   state_next = ST_COOL;
        else if (tmr_done_c)  state_next = ST_LVDS_WAIT;
      end
      ST_LVDS_WAIT: begin
        if (!enableRequest || timeout_c)                   state_next = ST_LVDS_OFF;
        else if (vsync_rise_c && (frame_cnt == LIM_FRAMES)) state_next = ST_BL_WAIT;
      end
      ST_BL_WAIT: begin
        tmr_limit = LIM_BL_ON;
        if (!enableRequest || timeout_c) state_next = ST_BL_OFF;
        else if (tmr_done_c)             state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enableRequest || timeout_c) state_next = ST_BL_OFF;
      end
      ST_BL_OFF: begin
        tmr_limit = LIM_BL_OFF;
        if (tmr_done_c) state_next = ST_LVDS_OFF;
      end
      ST_LVDS_OFF: begin
        tmr_limit = LIM_LVDS_OFF;
        if (tmr_done_c) state_next = ST_COOL;
      end
      ST_COOL: begin
        tmr_limit = LIM_COOL;
        if (tmr_done_c) state_next = ST_OFF;
      end
      default: state_next = ST_OFF;
    endcase
    if (timeout_c) fault_next = 1'b1;
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else begin
      ctrl <= decode_state(state);
    end
  end

  assign panelVddEn  = ctrl.vdd;
  assign lvdsEnable  = ctrl.lvds;
  assign blankData   = ctrl.blank;
  assign backlightEn = ctrl.backlight;
  assign panelReady  = ctrl.ready;
  assign seqState    = state;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer: scripted sequences push timed output-change
// events to a scoreboard; a monitor pops one per observed output change.
module tb_lcd_power_sequencer;
  import lcd_power_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vsync = 1'b0;
  logic       vdd, lvds, blank, bl, ready, fault;
  logic [2:0] st;
  logic [5:0] outs;

  lcd_power_sequencer dut (
    .pixelClock    (clk),
    .reset         (rst),
    .enableRequest (en),
    .vsync         (vsync),
    .panelVddEn    (vdd),
    .lvdsEnable    (lvds),
    .blankData     (blank),
    .backlightEn   (bl),
    .panelReady    (ready),
    .fault         (fault),
    .seqState      (st)
  );

  always #5 clk = ~clk;

  assign outs = {fault, vdd, lvds, blank, bl, ready};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // vsync source: rises at negedges vs_base + k*vs_per while vs_base <= cyc < vs_end
  int vs_base = 0;
  int vs_end  = 0;
  int vs_per  = 40;
  always @(negedge clk)
    vsync = (cyc >= vs_base) && (cyc < vs_end) && (((cyc - vs_base) % vs_per) < (vs_per / 2));

  typedef struct {
    int         cyc;
    logic [5:0] outs;
  } exp_t;
  exp_t sb[$];

  task automatic expect_at(input int c, input logic [5:0] o);
    exp_t e;
    e.cyc  = c;
    e.outs = o;
    sb.push_back(e);
  endtask

  logic [5:0] prev = '0;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && (outs !== prev)) begin
      if (sb.size() == 0) begin
        chk("unexpected_change", 32'(outs), 32'(prev));
      end else begin
        e = sb.pop_front();
        chk($sformatf("evt%0d_cycle", e.cyc), 32'(cyc), 32'(e.cyc));
        chk($sformatf("evt%0d_outs", e.cyc), 32'(outs), 32'(e.outs));
      end
      prev = outs;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Power-up with VDD_ON entered at posedge t0+1 and vsync period p from t0+12.
  task automatic push_powerup(input int t0, input int p);
    vs_base = t0 + 12;
    vs_per  = p;
    vs_end  = 32'h7fff_ffff;
    expect_at(t0 + 2,      6'b010000);
    expect_at(t0 + 12,     6'b011100);
    expect_at(t0 + 14 + p, 6'b011000);
    expect_at(t0 + 22 + p, 6'b011011);
  endtask

  int t0, d0, a0, f0, r0, k, last;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(st), 32'(ST_OFF));
    chk("reset_outs", 32'(outs), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // first power-up: no cool-down wait after reset
    t0 = cyc;
    en = 1'b1;
    push_powerup(t0, 40);
    wait_until(t0 + 1);  chk("pu_vdd_on", 32'(st), 32'(ST_VDD_ON));
    wait_until(t0 + 11); chk("pu_lvds_wait", 32'(st), 32'(ST_LVDS_WAIT));
    wait_until(t0 + 61); chk("pu_run", 32'(st), 32'(ST_RUN));
    wait_until(t0 + 200);

    // orderly power-down from RUN
    d0     = cyc;
    en     = 1'b0;
    vs_end = d0 + 1;
    expect_at(d0 + 2,  6'b011100);
    expect_at(d0 + 10, 6'b010000);
    expect_at(d0 + 16, 6'b000000);
    wait_until(d0 + 34); chk("pd_cool", 32'(st), 32'(ST_COOL));
    wait_until(d0 + 35); chk("pd_off", 32'(st), 32'(ST_OFF));

    // abort 5 cycles into VDD_ON, then re-request during COOL
    wait_until(d0 + 40);
    a0 = cyc;
    en = 1'b1;
    expect_at(a0 + 2, 6'b010000);
    wait_until(a0 + 5);
    en = 1'b0;
    expect_at(a0 + 7, 6'b000000);
    wait_until(a0 + 6);  chk("abort_cool", 32'(st), 32'(ST_COOL));
    wait_until(a0 + 10);
    en = 1'b1;
    push_powerup(a0 + 26, 100);
    wait_until(a0 + 25); chk("rereq_still_cool", 32'(st), 32'(ST_COOL));
    wait_until(a0 + 26); chk("rereq_off", 32'(st), 32'(ST_OFF));
    wait_until(a0 + 27); chk("rereq_vdd_on", 32'(st), 32'(ST_VDD_ON));

    // vsync every 100 cycles lands exactly on watchdog expiry: must not fault
    t0 = a0 + 26;
    wait_until(t0 + 600);
    chk("edge_at_expiry_run", 32'(st), 32'(ST_RUN));

    // stop vsync: fault exactly 100 cycles after the last edge
    k      = (cyc - vs_base) / vs_per + 1;
    last   = vs_base + k * vs_per;
    vs_end = last + 1;
    expect_at(last + 101, 6'b111011);
    expect_at(last + 102, 6'b111100);
    expect_at(last + 110, 6'b110000);
    expect_at(last + 116, 6'b100000);
    wait_until(last + 101); chk("timeout_bl_off", 32'(st), 32'(ST_BL_OFF));
    wait_until(last + 135); chk("timeout_off", 32'(st), 32'(ST_OFF));
    wait_until(last + 160); chk("fault_blocks_repower", 32'(st), 32'(ST_OFF));

    // fault clears in OFF with request low; then re-power
    f0 = cyc;
    en = 1'b0;
    expect_at(f0 + 1, 6'b000000);
    wait_until(f0 + 3);
    t0 = cyc;
    en = 1'b1;
    push_powerup(t0, 40);
    wait_until(t0 + 80); chk("pu3_run", 32'(st), 32'(ST_RUN));

    // asynchronous reset in RUN
    vs_end = cyc + 1;
    expect_at(cyc + 1, 6'b000000);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs), 32'd0);
    chk("async_reset_state", 32'(st), 32'(ST_OFF));
    repeat (2) @(negedge clk);
    r0  = cyc;
    rst = 1'b0;
    expect_at(r0 + 2, 6'b010000);
    wait_until(r0 + 1);  chk("post_reset_vdd_on", 32'(st), 32'(ST_VDD_ON));
    wait_until(r0 + 4);
    en = 1'b0;
    expect_at(r0 + 6, 6'b000000);
    wait_until(r0 + 40); chk("final_off", 32'(st), 32'(ST_OFF));

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_power_sequencer.md
LCD_POWER_SEQUENCER -- requirements
Module: lcd_power_sequencer

Interface
REQ-001 Parameter T_VDD_LVDS, default 10: cycles from panel VDD on to LVDS enable.
REQ-002 Parameter BLANK_FRAMES, default 2: vsync frames sent blanked before unblank.
REQ-003 Parameter T_BL_ON, default 8: cycles from unblank to backlight on.
REQ-004 Parameter T_BL_OFF, default 8: cycles from backlight off to LVDS disable.
REQ-005 Parameter T_LVDS_OFF, default 6: cycles from LVDS disable to VDD off.
REQ-006 Parameter T_COOL, default 20: minimum VDD-off cycles before re-power.
REQ-007 Parameter VSYNC_TIMEOUT, default 100: max cycles between vsync rising edges while LVDS is live.
REQ-008 All timing parameters SHALL be >= 1 and < 2^24.
REQ-009 pixelClock  in  1  RGB pixel clock; the only clock.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 enableRequest  in  1  level; 1 = panel on requested.
REQ-012 vsync  in  1  STM32 vsync, pixelClock domain; rising edge = frame start.
REQ-013 panelVddEn  out  1  panel supply enable.
REQ-014 lvdsEnable  out  1  serializer enable; 0 forces LVDS clock and data lines low.
REQ-015 blankData  out  1  1 forces serializer RGB inputs to zero.
REQ-016 backlightEn  out  1  backlight enable.
REQ-017 panelReady  out  1  high only in RUN.
REQ-018 fault  out  1  sticky vsync-timeout flag.
REQ-019 seqState  out  3  current state encoding.

Function
REQ-020 States SHALL be OFF=0, VDD_ON=1, LVDS_WAIT=2, BL_WAIT=3, RUN=4, BL_OFF=5, LVDS_OFF=6, COOL=7.
REQ-021 Outputs SHALL be registered and decoded from state, with one-cycle latency after each transition: OFF, COOL all 0; VDD_ON vdd; LVDS_WAIT vdd, lvds, blank; BL_WAIT vdd, lvds; RUN vdd, lvds, backlight, ready; BL_OFF vdd, lvds, blank; LVDS_OFF vdd.
REQ-022 A 24-bit state timer SHALL clear on every state entry; a timed state exits when timer == parameter-1, so it lasts exactly parameter cycles.
REQ-023 OFF -> VDD_ON when enableRequest=1 and fault=0.
REQ-024 VDD_ON -> LVDS_WAIT after T_VDD_LVDS cycles; if enableRequest=0 -> COOL (the drop wins over timer expiry in the same cycle).
REQ-025 LVDS_WAIT SHALL count vsync rising edges (registered-vsync edge detect) and -> BL_WAIT on edge number BLANK_FRAMES; if enableRequest=0 -> LVDS_OFF.
REQ-026 BL_WAIT -> RUN after T_BL_ON cycles; if enableRequest=0 -> BL_OFF.
REQ-027 RUN -> BL_OFF when enableRequest=0.
REQ-028 BL_OFF -> LVDS_OFF after T_BL_OFF; LVDS_OFF -> COOL after T_LVDS_OFF; COOL -> OFF after T_COOL; enableRequest SHALL be ignored in these states, and re-power proceeds from OFF.
REQ-029 A vsync watchdog SHALL clear on LVDS_WAIT entry and on each vsync rising edge, count in LVDS_WAIT, BL_WAIT and RUN, and on reaching VSYNC_TIMEOUT set fault and force LVDS_WAIT -> LVDS_OFF, or BL_WAIT/RUN -> BL_OFF.
REQ-030 Timeout and enableRequest drop in the same cycle SHALL take the same exit and still set fault.
REQ-031 fault SHALL clear only in OFF with enableRequest=0.
REQ-032 A vsync edge in the same cycle as the watchdog reaching VSYNC_TIMEOUT SHALL count as a valid edge (no fault).

Reset
REQ-033 On reset assertion: state OFF, all outputs 0, timers, frame count and fault cleared, edge-detect register 0, regardless of the current state (mid-sequence reset drops VDD immediately).
REQ-034 After reset release, the first power-up SHALL NOT wait T_COOL.

Structure
REQ-035 A shared package SHALL hold the state encoding constants and the default timing parameter values.
REQ-036 One sub-module, seq_timer (24-bit clear/count/compare with done), SHALL be used for the state timer and the vsync watchdog.

Verification (default parameters, vsync period 40 cycles unless stated)
REQ-037 Power-up: enableRequest 0->1 -> vdd at +1, lvds+blank at +11, blank 0 at 2nd vsync edge, backlight+ready 8 cycles later.
REQ-038 Power-down from RUN: enableRequest 0 -> backlight 0, blank 1; lvds 0 after 8; vdd 0 after 6 more; state OFF after 20 more.
REQ-039 Abort: enableRequest drops 5 cycles into VDD_ON -> COOL, vdd 0, lvds never 1.
REQ-040 Timeout: stop vsync in RUN -> fault 1 exactly 100 cycles after the last edge, shutdown via BL_OFF, no re-power until enableRequest toggles 0->1.
REQ-041 Re-request in COOL: enableRequest 1 during COOL -> OFF after T_COOL completes, then VDD_ON the next cycle.
REQ-042 Reset asserted in RUN -> all outputs 0 asynchronously; state OFF.
